// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, key-length decoding, Rcon stepping and the S-box,
// shared by the key schedule and the cipher core.
package aes_pkg;
   localparam logic [1:0] KEYLEN_128 = 2'd0;
   localparam logic [1:0] KEYLEN_192 = 2'd1;
   localparam logic [1:0] KEYLEN_256 = 2'd2;
   localparam logic [7:0] RCON_INIT  = 8'h01;

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_e;

   localparam logic [7:0] SBOX_T [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      return kl == KEYLEN_128 ? 4'd4 : kl == KEYLEN_192 ? 4'd6 : kl == KEYLEN_256 ? 4'd8 : 4'd0;
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      return kl == KEYLEN_128 ? 4'd10 : kl == KEYLEN_192 ? 4'd12 : kl == KEYLEN_256 ? 4'd14 : 4'd0;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_T[b];
   endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord, four parallel S-box lookups on a 32-bit word.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] i_w,
   output logic [31:0] o_w
);
   assign o_w = {sbox(i_w[31:24]), sbox(i_w[23:16]), sbox(i_w[15:8]), sbox(i_w[7:0])};
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: sequential AES-128/192/256 key expansion, one word per cycle,
// round keys 0..Nr streamed as 128-bit beats on a valid/ready interface.
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int MAX_NK = 8,
   parameter int RK_W   = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      key_len,
   input  logic [0:255]    key,
   output logic            busy,
   output logic            cfg_err,
   output logic            rk_valid,
   input  logic            rk_ready,
   output logic [0:RK_W-1] rk_data,
   output logic [3:0]      rk_index,
   output logic            rk_last
);
   state_e      r_state;
   logic [31:0] r_win [0:7];
   logic [31:0] r_asm [0:3];
   logic [5:0]  r_cnt;
   logic [2:0]  r_ph;
   logic [7:0]  r_rcon;
   logic [3:0]  r_nk;
   logic [3:0]  r_nr;

   logic [31:0] w_kw [0:7];
   logic [31:0] w_load [0:7];
   logic [31:0] w_tap, w_sub_in, w_sub_out, w_t, w_new;
   logic [3:0]  w_nk;
   logic        w_bad, w_accept, w_key_word, w_rot, w_sub_only, w_stall, w_step, w_fin;

   // The key is loaded reversed so that, while i < Nk, tap Nk-1 replays key word i.
   always_comb begin
      w_nk = nk_of(key_len);
      w_bad = (w_nk == 4'd0) || (int'(w_nk) > MAX_NK);
      w_accept = (r_state == S_IDLE) && start && !w_bad;
      for (int j = 0; j < 8; j++) w_kw[j] = key[32*j +: 32];
      for (int j = 0; j < 8; j++) w_load[j] = (4'(j) < w_nk) ? w_kw[3'(w_nk - 4'd1 - 4'(j))] : '0;
      w_tap = r_win[3'(r_nk - 4'd1)];
      w_key_word = r_cnt < {2'b00, r_nk};
      w_rot = !w_key_word && (r_ph == 3'd0);
      w_sub_only = !w_key_word && (r_nk == 4'd8) && (r_ph == 3'd4);
      w_sub_in = w_rot ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];
      w_t = w_rot ? (w_sub_out ^ {r_rcon, 24'h0}) : w_sub_only ? w_sub_out : r_win[0];
      w_new = w_key_word ? w_tap : (w_tap ^ w_t);
      w_stall = (r_cnt[1:0] == 2'd3) && rk_valid && !rk_ready;
      w_step = (r_state == S_GEN) && !w_stall;
      w_fin = r_cnt == {r_nr, 2'b11};
   end

   aes_sub_word u_sub (.i_w(w_sub_in), .o_w(w_sub_out));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         busy     <= 1'b0;
         cfg_err  <= 1'b0;
         rk_valid <= 1'b0;
         rk_data  <= '0;
         rk_index <= '0;
         rk_last  <= 1'b0;
         r_win    <= '{default: '0};
         r_asm    <= '{default: '0};
         r_cnt    <= '0;
         r_ph     <= '0;
         r_rcon   <= '0;
         r_nk     <= '0;
         r_nr     <= '0;
      end else begin
         cfg_err <= (r_state == S_IDLE) && start && w_bad;
         if (rk_valid && rk_ready) rk_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_state <= S_GEN;
               busy    <= 1'b1;
               r_win   <= w_load;
               r_cnt   <= '0;
               r_ph    <= '0;
               r_rcon  <= RCON_INIT;
               r_nk    <= w_nk;
               r_nr    <= nr_of(key_len);
            end
            S_GEN: if (w_step) begin
               r_win[0] <= w_new;
               for (int j = 1; j < 8; j++) r_win[j] <= r_win[j-1];
               r_cnt <= r_cnt + 6'd1;
               r_ph <= (r_ph == 3'(r_nk - 4'd1)) ? 3'd0 : r_ph + 3'd1;
               if (w_rot) r_rcon <= xtime(r_rcon);
               r_asm[r_cnt[1:0]] <= w_new;
               if (r_cnt[1:0] == 2'd3) begin
                  rk_valid <= 1'b1;
                  rk_data  <= {r_asm[0], r_asm[1], r_asm[2], w_new};
                  rk_index <= r_cnt[5:2];
                  rk_last  <= w_fin;
               end
               if (w_fin) r_state <= S_DRAIN;
            end
            S_DRAIN: if (rk_valid && rk_ready) begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: known-answer vectors, random keys with backpressure against a
// GF(2^8)-derived reference model, and control corner cases.
module tb_aes_key_schedule_seq;
   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
   logic [1:0]   key_len = 2'd0;
   logic [0:255] key = '0;
   logic         busy, cfg_err, rk_valid, rk_last;
   logic [0:127] rk_data;
   logic [3:0]   rk_index;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   aes_key_schedule_seq #(.MAX_NK(8), .RK_W(128)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
      .busy(busy), .cfg_err(cfg_err), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last)
   );

   typedef struct { logic [127:0] d; int idx; bit last; } beat_t;
   typedef struct { logic [1:0] kl; logic [255:0] key; int nbeats; int lastc; } vec_t;
   typedef struct { logic [1:0] kl; int widx; logic [31:0] w; } kat_t;

   logic [7:0]  sb [256];
   logic [31:0] mw [60];
   int          m_nr;
   beat_t       beats [$];
   int          first_cyc, last_cyc;
   vec_t        vecs [3];
   kat_t        kats [13];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] dv;
      dv = {v, v} << n;
      return dv[15:8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   // Expanded key straight from the FIPS-197 recurrence.
   function automatic void model(input logic [1:0] kl, input logic [255:0] k);
      int nk;
      logic [7:0] rc;
      logic [31:0] t;
      nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
      m_nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(m_nr+1); i++) begin
         t = mw[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % 8 == 4) t = subw(t);
         mw[i] = mw[i-nk] ^ t;
      end
   endfunction

   function automatic logic [255:0] pad(input logic [1:0] kl, input logic [255:0] k);
      logic [255:0] mask, junk;
      int nk;
      nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
      mask = ~(256'b0) << (256 - 32*nk);
      for (int i = 0; i < 8; i++) junk[32*i +: 32] = $urandom();
      return (k & mask) | (junk & ~mask);
   endfunction

   // inj: 0 none, 1 start pulse mid-run, 2 start together with the final handshake
   task automatic run(input logic [1:0] kl, input logic [255:0] k, input int pct, input int inj);
      logic [127:0] hd;
      int hi, c;
      bit hl, held, done;
      beats.delete();
      first_cyc = -1;
      last_cyc = -1;
      held = 0;
      done = 0;
      hd = '0;
      hi = 0;
      hl = 0;
      key_len = kl;
      key = k;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      check("busy_after_start", 128'(busy), 128'(1));
      while (!done && c < 3000) begin
         rk_ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
         if (inj == 1 && c == 9) begin
            start = 1'b1;
            key_len = 2'd2;
            key = ~k;
         end
         if (inj == 1 && c == 10) start = 1'b0;
         if (held) begin
            check("stall_valid", 128'(rk_valid), 128'(1));
            check("stall_data", rk_data, hd);
            check("stall_index", 128'(rk_index), 128'(hi));
            check("stall_last", 128'(rk_last), 128'(hl));
         end
         if (rk_valid && first_cyc < 0) first_cyc = c;
         if (rk_valid && rk_ready) begin
            beats.push_back('{rk_data, int'(rk_index), rk_last});
            if (rk_last) begin
               last_cyc = c;
               done = 1;
            end
         end
         held = rk_valid && !rk_ready;
         hd = rk_data;
         hi = int'(rk_index);
         hl = rk_last;
         if (done && inj == 2) begin
            start = 1'b1;
            key_len = 2'd0;
         end
         @(negedge clk);
         c++;
      end
      if (!done) check("run_timeout", 128'(0), 128'(1));
      start = 1'b0;
      rk_ready = 1'b1;
      check("busy_after_last", 128'(busy), 128'(0));
      check("valid_after_last", 128'(rk_valid), 128'(0));
   endtask

   task automatic check_model(input string tag);
      check({tag, "_nbeats"}, 128'(beats.size()), 128'(m_nr + 1));
      foreach (beats[b]) begin
         if (b <= m_nr) begin
            check({tag, "_data"}, beats[b].d, {mw[4*b], mw[4*b+1], mw[4*b+2], mw[4*b+3]});
            check({tag, "_index"}, 128'(beats[b].idx), 128'(b));
            check({tag, "_last"}, 128'(beats[b].last), 128'(b == m_nr));
         end
      end
   endtask

   task automatic check_kat(input logic [1:0] kl, input string tag);
      logic [127:0] d;
      for (int j = 0; j < 13; j++) begin
         if (kats[j].kl == kl) begin
            if (kats[j].widx / 4 < beats.size()) begin
               d = beats[kats[j].widx / 4].d;
               check({tag, "_kat_word"}, 128'(d[127 - 32*(kats[j].widx % 4) -: 32]), 128'(kats[j].w));
            end else check({tag, "_kat_missing"}, 128'(beats.size()), 128'(kats[j].widx / 4 + 1));
         end
      end
   endtask

   initial begin
      int seen, n;
      logic [7:0] inv;
      logic [1:0] kl;
      logic [255:0] rk;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      vecs[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 11, 45};
      vecs[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 13, 53};
      vecs[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 15, 61};
      kats[0]  = '{2'd0, 4,  32'ha0fafe17};
      kats[1]  = '{2'd0, 5,  32'h88542cb1};
      kats[2]  = '{2'd0, 6,  32'h23a33939};
      kats[3]  = '{2'd0, 7,  32'h2a6c7605};
      kats[4]  = '{2'd0, 40, 32'hd014f9a8};
      kats[5]  = '{2'd0, 41, 32'hc9ee2589};
      kats[6]  = '{2'd0, 42, 32'he13f0cc8};
      kats[7]  = '{2'd0, 43, 32'hb6630ca6};
      kats[8]  = '{2'd1, 6,  32'hfe0c91f7};
      kats[9]  = '{2'd1, 51, 32'h01002202};
      kats[10] = '{2'd2, 8,  32'h9ba35411};
      kats[11] = '{2'd2, 12, 32'ha8b09c1a};
      kats[12] = '{2'd2, 59, 32'h706c631e};

      @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_cfg_err", 128'(cfg_err), 128'(0));
      check("rst_valid", 128'(rk_valid), 128'(0));
      check("rst_last", 128'(rk_last), 128'(0));
      check("rst_data", rk_data, 128'(0));
      check("rst_index", 128'(rk_index), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Known answers with rk_ready held high, including first/last beat timing.
      for (int v = 0; v < 3; v++) begin
         model(vecs[v].kl, vecs[v].key);
         run(vecs[v].kl, pad(vecs[v].kl, vecs[v].key), 100, 0);
         check("kat_nbeats", 128'(beats.size()), 128'(vecs[v].nbeats));
         check("kat_first_cycle", 128'(first_cyc), 128'(5));
         check("kat_last_cycle", 128'(last_cyc), 128'(vecs[v].lastc));
         check_kat(vecs[v].kl, "nominal");
         check_model("nominal");
      end

      for (int v = 0; v < 3; v++) begin
         model(vecs[v].kl, vecs[v].key);
         run(vecs[v].kl, pad(vecs[v].kl, vecs[v].key), 30, 0);
         check_kat(vecs[v].kl, "bp");
         check_model("bp");
      end

      for (n = 0; n < 6; n++) begin
         kl = 2'($urandom_range(0, 2));
         for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom();
         model(kl, rk);
         run(kl, rk, int'($urandom_range(25, 100)), 0);
         check_model("rand");
      end

      key_len = 2'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("cfg_err_pulse", 128'(cfg_err), 128'(1));
      check("cfg_err_busy", 128'(busy), 128'(0));
      @(negedge clk);
      check("cfg_err_one_cycle", 128'(cfg_err), 128'(0));
      check("cfg_err_idle", 128'(busy), 128'(0));

      model(vecs[0].kl, vecs[0].key);
      run(vecs[0].kl, vecs[0].key, 100, 1);
      check_kat(2'd0, "start_busy");
      check_model("start_busy");
      run(vecs[0].kl, vecs[0].key, 60, 2);
      check_model("start_at_last");
      @(negedge clk);
      check("start_at_last_idle", 128'(busy), 128'(0));

      // Asynchronous reset while AES-256 round key 5 is being presented.
      key_len = 2'd2;
      key = vecs[2].key;
      rk_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(rk_valid && rk_index == 4'd5) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_round5", 128'(n < 200), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 128'(rk_valid), 128'(0));
      check("async_rst_busy", 128'(busy), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rk_valid || busy) seen++;
      end
      check("no_partial_after_rst", 128'(seen), 128'(0));
      model(vecs[0].kl, vecs[0].key);
      run(vecs[0].kl, vecs[0].key, 100, 0);
      check("post_rst_last_cycle", 128'(last_cyc), 128'(45));
      check_kat(2'd0, "post_rst");
      check_model("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
